// File: rtl/ysyx_24100006_key_demux_pkg.sv
// Shared definitions for the key-addressed request demux: FSM state encoding
// and the default watchdog limit.
package ysyx_24100006_key_demux_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/ysyx_24100006_key_demux_key_match.sv
// Combinational key compare against a packed per-port key table; duplicate
// keys resolve to the lowest port index, so sel is always one-hot or zero.
module ysyx_24100006_key_match #(
  parameter int NR_PORT = 4,
  parameter int KEY_LEN = 4
) (
  input  logic [KEY_LEN-1:0]         key,
  input  logic [NR_PORT*KEY_LEN-1:0] key_table,
  output logic [NR_PORT-1:0]         sel,
  output logic                       hit
);

  always_comb begin
    sel = '0;
    for (int n = NR_PORT - 1; n >= 0; n--) begin
      if (key == key_table[KEY_LEN*n +: KEY_LEN]) begin
        sel    = '0;
        sel[n] = 1'b1;
      end
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/ysyx_24100006_key_demux.sv
// Key-addressed 1-to-N request router, one transaction outstanding at a time.
// Optional watchdog: define YSYX_24100006_KEY_DEMUX_TIMEOUT_EN.
module ysyx_24100006_key_demux
  import ysyx_24100006_key_demux_pkg::*;
#(
  parameter int NR_PORT     = 4,
  parameter int KEY_LEN     = 4,
  parameter int REQ_LEN     = 32,
  parameter int RSP_LEN     = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NR_PORT*KEY_LEN-1:0] key_table,
  input  logic                       up_req_valid,
  output logic                       up_req_ready,
  input  logic [KEY_LEN-1:0]         up_req_key,
  input  logic [REQ_LEN-1:0]         up_req_data,
  output logic [NR_PORT-1:0]         dn_req_valid,
  input  logic [NR_PORT-1:0]         dn_req_ready,
  output logic [REQ_LEN-1:0]         dn_req_data,
  input  logic [NR_PORT-1:0]         dn_rsp_valid,
  output logic [NR_PORT-1:0]         dn_rsp_ready,
  input  logic [NR_PORT*RSP_LEN-1:0] dn_rsp_data,
  output logic                       up_rsp_valid,
  input  logic                       up_rsp_ready,
  output logic [RSP_LEN-1:0]         up_rsp_data,
  output logic                       up_rsp_err,
  output state_t                     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid, once raised, holds with stable payload until taken.

  state_t               state;
  logic [NR_PORT-1:0]   sel_q;
  logic [NR_PORT-1:0]   match_sel;
  logic                 match_hit;
  logic                 req_hs;
  logic                 rsp_hs;
  logic [RSP_LEN-1:0]   rsp_sel_data;

  ysyx_24100006_key_match #(
    .NR_PORT (NR_PORT),
    .KEY_LEN (KEY_LEN)
  ) u_key_match (
    .key       (up_req_key),
    .key_table (key_table),
    .sel       (match_sel),
    .hit       (match_hit)
  );

  assign req_hs    = |(dn_req_valid & dn_req_ready);
  assign rsp_hs    = |(dn_rsp_valid & sel_q);
  assign dbg_state = state;

  always_comb begin
    rsp_sel_data = '0;
    for (int n = 0; n < NR_PORT; n++) begin
      if (sel_q[n]) rsp_sel_data = rsp_sel_data | dn_rsp_data[RSP_LEN*n +: RSP_LEN];
    end
  end

`ifdef YSYX_24100006_KEY_DEMUX_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt;
  logic             tmo;
  assign tmo = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      sel_q        <= '0;
      up_req_ready <= 1'b1;
      dn_req_valid <= '0;
      dn_req_data  <= '0;
      dn_rsp_ready <= '0;
      up_rsp_valid <= 1'b0;
      up_rsp_data  <= '0;
      up_rsp_err   <= 1'b0;
`ifdef YSYX_24100006_KEY_DEMUX_TIMEOUT_EN
      cnt          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (up_req_valid && up_req_ready) begin
            up_req_ready <= 1'b0;
            dn_req_data  <= up_req_data;
            sel_q        <= match_sel;
`ifdef YSYX_24100006_KEY_DEMUX_TIMEOUT_EN
            cnt          <= '0;
`endif
            if (match_hit) begin
              state        <= REQ;
              dn_req_valid <= match_sel;
            end else begin
              state        <= ERR;
              up_rsp_valid <= 1'b1;
              up_rsp_err   <= 1'b1;
              up_rsp_data  <= '0;
            end
          end
        end
        REQ: begin
          if (req_hs) begin
            state        <= RESP;
            dn_req_valid <= '0;
            dn_rsp_ready <= sel_q;
`ifdef YSYX_24100006_KEY_DEMUX_TIMEOUT_EN
            cnt          <= cnt + CNT_W'(1);
          end else if (tmo) begin
            state        <= ERR;
            dn_req_valid <= '0;
            up_rsp_valid <= 1'b1;
            up_rsp_err   <= 1'b1;
            up_rsp_data  <= '0;
          end else begin
            cnt          <= cnt + CNT_W'(1);
`endif
          end
        end
        RESP: begin
          if (rsp_hs) begin
            state        <= DONE;
            dn_rsp_ready <= '0;
            up_rsp_valid <= 1'b1;
            up_rsp_err   <= 1'b0;
            up_rsp_data  <= rsp_sel_data;
`ifdef YSYX_24100006_KEY_DEMUX_TIMEOUT_EN
          end else if (tmo) begin
            state        <= ERR;
            dn_rsp_ready <= '0;
            up_rsp_valid <= 1'b1;
            up_rsp_err   <= 1'b1;
            up_rsp_data  <= '0;
          end else begin
            cnt          <= cnt + CNT_W'(1);
`endif
          end
        end
        DONE, ERR: begin
          // Ready rises only after the response retires, so no same-cycle accept.
          if (up_rsp_ready) begin
            state        <= IDLE;
            up_rsp_valid <= 1'b0;
            up_rsp_err   <= 1'b0;
            up_req_ready <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          up_req_ready <= 1'b1;
          dn_req_valid <= '0;
          dn_rsp_ready <= '0;
          up_rsp_valid <= 1'b0;
          up_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
